// File: rtl/chipmunk_loader_if.sv
// Byte-stream and memory-write bus between the chipmunk loader and its environment.
// A byte moves on every rising edge where inValid && inReady; the source holds inData
// stable while inValid is high, and inReady never waits on inValid.
interface chipmunk_loader_if #(
  parameter int addrSize = 12
);
  logic [7:0]          inData;
  logic                inValid;
  logic                inReady;
  logic [addrSize-1:0] memAddr;
  logic [7:0]          memData;
  logic                weMem;
  logic                memSel;

  modport master (
    input  inData, inValid,
    output inReady, memAddr, memData, weMem, memSel
  );

  modport slave (
    output inData, inValid,
    input  inReady, memAddr, memData, weMem, memSel
  );
endinterface

// File: rtl/chipmunk_loader.sv
// Serial image loader: parses a length/address header, writes the payload to memory,
// verifies an 8-bit sum and then releases the CPU. Optional watchdog: LOADER_WATCHDOG_EN.
module chipmunk_loader #(
  parameter int addrSize    = 12,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  chipmunk_loader_if.master   bus,
  input  logic                cpuDone,
  output logic                cpuReset,
  output logic [addrSize-1:0] cpuStartPC,
  output logic                busy,
  output logic                runDone,
  output logic                loadError,
  output logic [1:0]          errCode,
  output logic [3:0]          dbgState
);

  typedef enum logic [3:0] {
    IDLE, LEN_LO, LEN_HI, ADR_LO, ADR_HI, DATA, CSUM, RUN, DONE, ERR
  } state_t;

  state_t              state;
  logic [7:0]          loByte;
  logic [7:0]          csum;
  logic [addrSize-1:0] lenCnt;
  logic [addrSize-1:0] curAddr;
  logic                accept;

`ifdef LOADER_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdogCnt;
  logic          wdogHit;
  assign wdogHit = (wdogCnt == WW'(WDOG_CYCLES - 1));
`endif

  // memSel spans the same states as inReady; the final payload write lands while in CSUM.
  assign bus.inReady = state inside {LEN_LO, LEN_HI, ADR_LO, ADR_HI, DATA, CSUM};
  assign bus.memSel  = state inside {LEN_LO, LEN_HI, ADR_LO, ADR_HI, DATA, CSUM};
  assign busy        = !(state inside {IDLE, DONE, ERR});
  assign dbgState    = state;
  assign accept      = bus.inValid && bus.inReady;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      loByte      <= '0;
      csum        <= '0;
      lenCnt      <= '0;
      curAddr     <= '0;
      bus.memAddr <= '0;
      bus.memData <= '0;
      bus.weMem   <= 1'b1;
      cpuReset    <= 1'b0;
      cpuStartPC  <= '0;
      runDone     <= 1'b0;
      loadError   <= 1'b0;
      errCode     <= 2'b00;
`ifdef LOADER_WATCHDOG_EN
      wdogCnt     <= '0;
`endif
    end else begin
      bus.weMem <= 1'b1;
      cpuReset  <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state     <= LEN_LO;
            runDone   <= 1'b0;
            loadError <= 1'b0;
            errCode   <= 2'b00;
            csum      <= '0;
          end
        end
        LEN_LO: if (accept) begin
          loByte <= bus.inData;
          state  <= LEN_HI;
        end
        LEN_HI: if (accept) begin
          lenCnt <= addrSize'({bus.inData, loByte});
          state  <= ADR_LO;
        end
        ADR_LO: if (accept) begin
          loByte <= bus.inData;
          state  <= ADR_HI;
        end
        ADR_HI: if (accept) begin
          curAddr    <= addrSize'({bus.inData, loByte});
          cpuStartPC <= addrSize'({bus.inData, loByte});
          state      <= (lenCnt == '0) ? CSUM : DATA;
        end
        DATA: if (accept) begin
          bus.memAddr <= curAddr;
          bus.memData <= bus.inData;
          bus.weMem   <= 1'b0;
          curAddr     <= curAddr + addrSize'(1);
          lenCnt      <= lenCnt - addrSize'(1);
          csum        <= csum + bus.inData;
          if (lenCnt == addrSize'(1)) state <= CSUM;
        end
        CSUM: if (accept) begin
          if (bus.inData == csum) begin
            state <= RUN;
`ifdef LOADER_WATCHDOG_EN
            wdogCnt <= '0;
`endif
          end else begin
            state     <= ERR;
            loadError <= 1'b1;
            errCode   <= 2'b01;
          end
        end
        RUN: begin
          // cpuReset only rises when the next cycle is still RUN, so it reads 0 on the
          // first RUN cycle and never leaks into DONE or ERR.
          if (cpuDone) begin
            state   <= DONE;
            runDone <= 1'b1;
          end
`ifdef LOADER_WATCHDOG_EN
          else if (wdogHit) begin
            state     <= ERR;
            loadError <= 1'b1;
            errCode   <= 2'b10;
          end else begin
            wdogCnt  <= wdogCnt + WW'(1);
            cpuReset <= 1'b1;
          end
`else
          else begin
            cpuReset <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chipmunk_loader.sv
// Self-checking bench for chipmunk_loader: image table, write scoreboard, reset and watchdog sequences.
module tb_chipmunk_loader;

  localparam int AW = 12;
  localparam logic [3:0] S_IDLE = 4'd0, S_RUN = 4'd7, S_DONE = 4'd8, S_ERR = 4'd9;

  typedef struct packed {
    logic [15:0]      len;
    logic [15:0]      addr;
    logic [3:0][7:0]  d;
    logic [7:0]       csum;
    logic             err;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          cpuDone = 1'b0;
  logic          cpuReset;
  logic [AW-1:0] cpuStartPC;
  logic          busy, runDone, loadError;
  logic [1:0]    errCode;
  logic [3:0]    dbgState;

  int tests  = 0;
  int failed = 0;
  logic [19:0] exp_q[$];
  vec_t vecs[5];

  chipmunk_loader_if #(.addrSize(AW)) ifc ();

  chipmunk_loader #(.addrSize(AW), .WDOG_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(ifc),
    .cpuDone(cpuDone), .cpuReset(cpuReset), .cpuStartPC(cpuStartPC),
    .busy(busy), .runDone(runDone), .loadError(loadError),
    .errCode(errCode), .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory-write monitor: every weMem pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (ifc.weMem === 1'b0) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_write: addr %0h data %0h", ifc.memAddr, ifc.memData);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("mem_write", {12'h0, ifc.memAddr, ifc.memData}, {12'h0, e});
        chk("memSel_during_write", {31'h0, ifc.memSel}, 32'h1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      ifc.inValid = 1'b0;
      repeat (gap) tick();
    end
    ifc.inData  = b;
    ifc.inValid = 1'b1;
    n = 0;
    while (!ifc.inReady && n < 20) begin
      tick();
      n++;
    end
    if (!ifc.inReady) chk("inReady_timeout", 32'h0, 32'h1);
    else tick();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"},     {28'h0, dbgState}, {28'h0, S_IDLE});
    chk({tag, "_inReady"},   {31'h0, ifc.inReady}, 32'h0);
    chk({tag, "_weMem"},     {31'h0, ifc.weMem}, 32'h1);
    chk({tag, "_memSel"},    {31'h0, ifc.memSel}, 32'h0);
    chk({tag, "_cpuReset"},  {31'h0, cpuReset}, 32'h0);
    chk({tag, "_startPC"},   {20'h0, cpuStartPC}, 32'h0);
    chk({tag, "_busy"},      {31'h0, busy}, 32'h0);
    chk({tag, "_runDone"},   {31'h0, runDone}, 32'h0);
    chk({tag, "_loadError"}, {31'h0, loadError}, 32'h0);
    chk({tag, "_errCode"},   {30'h0, errCode}, 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input int maxGap, input bit holdRun);
    logic [AW-1:0] a;
    int n;
    pulse_start();
    chk("busy_after_start", {31'h0, busy}, 32'h1);
    chk("flags_cleared", {29'h0, runDone, loadError, errCode}, 32'h0);
    cpuDone = 1'b1;
    tick();
    cpuDone = 1'b0;
    chk("cpuDone_ignored_in_load", {31'h0, runDone}, 32'h0);
    send_byte(v.len[7:0],   $urandom_range(0, maxGap));
    send_byte(v.len[15:8],  $urandom_range(0, maxGap));
    send_byte(v.addr[7:0],  $urandom_range(0, maxGap));
    send_byte(v.addr[15:8], $urandom_range(0, maxGap));
    n = int'(v.len[AW-1:0]);
    a = v.addr[AW-1:0];
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({a, v.d[i]});
      send_byte(v.d[i], $urandom_range(0, maxGap));
      a = a + 1'b1;
    end
    send_byte(v.csum, $urandom_range(0, maxGap));
    ifc.inValid = 1'b0;
    chk("writes_drained", exp_q.size(), 32'h0);
    if (v.err) begin
      chk("err_state",    {28'h0, dbgState}, {28'h0, S_ERR});
      chk("err_flag",     {31'h0, loadError}, 32'h1);
      chk("err_code",     {30'h0, errCode}, 32'h1);
      chk("err_busy",     {31'h0, busy}, 32'h0);
      repeat (3) tick();
      chk("err_cpuReset", {31'h0, cpuReset}, 32'h0);
      chk("err_memSel",   {31'h0, ifc.memSel}, 32'h0);
    end else begin
      chk("run_state",    {28'h0, dbgState}, {28'h0, S_RUN});
      chk("run_startPC",  {20'h0, cpuStartPC}, {20'h0, v.addr[AW-1:0]});
      chk("run_first_cpuReset", {31'h0, cpuReset}, 32'h0);
      chk("run_memSel",   {31'h0, ifc.memSel}, 32'h0);
      tick();
      chk("run_cpuReset", {31'h0, cpuReset}, 32'h1);
      pulse_start();
      chk("start_ignored_in_run", {28'h0, dbgState}, {28'h0, S_RUN});
      chk("run_inReady",  {31'h0, ifc.inReady}, 32'h0);
      if (holdRun) begin
`ifdef LOADER_WATCHDOG_EN
        repeat (13) tick();
        chk("wdog_still_run", {28'h0, dbgState}, {28'h0, S_RUN});
        tick();
        chk("wdog_state",    {28'h0, dbgState}, {28'h0, S_ERR});
        chk("wdog_flag",     {31'h0, loadError}, 32'h1);
        chk("wdog_code",     {30'h0, errCode}, 32'h2);
        chk("wdog_cpuReset", {31'h0, cpuReset}, 32'h0);
        return;
`else
        repeat (30) tick();
        chk("nowdog_still_run", {28'h0, dbgState}, {28'h0, S_RUN});
        chk("nowdog_no_error",  {29'h0, loadError, errCode}, 32'h0);
        chk("nowdog_cpuReset",  {31'h0, cpuReset}, 32'h1);
`endif
      end
      cpuDone = 1'b1;
      tick();
      cpuDone = 1'b0;
      chk("done_state",    {28'h0, dbgState}, {28'h0, S_DONE});
      chk("done_runDone",  {31'h0, runDone}, 32'h1);
      chk("done_busy",     {31'h0, busy}, 32'h0);
      chk("done_cpuReset", {31'h0, cpuReset}, 32'h0);
      chk("done_no_error", {29'h0, loadError, errCode}, 32'h0);
    end
  endtask

  initial begin
    logic [7:0] s;
    ifc.inData  = 8'h00;
    ifc.inValid = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b1;
    tick();

    vecs[0] = '{len: 16'h0003, addr: 16'h0010, d: {8'h00, 8'h83, 8'h05, 8'hA9}, csum: 8'h31, err: 1'b0};
    vecs[1] = '{len: 16'h0003, addr: 16'h0010, d: {8'h00, 8'h83, 8'h05, 8'hA9}, csum: 8'h30, err: 1'b1};
    vecs[2] = '{len: 16'h0000, addr: 16'h0200, d: '0, csum: 8'h00, err: 1'b0};
    vecs[3] = '{len: 16'h0002, addr: 16'h0FFF, d: {16'h0000, 8'h22, 8'h11}, csum: 8'h33, err: 1'b0};
    vecs[4] = '{len: 16'h0004, addr: 16'hFABC, d: '0, csum: 8'h00, err: 1'b0};
    s = 8'h00;
    for (int i = 0; i < 4; i++) begin
      vecs[4].d[i] = 8'($urandom_range(0, 255));
      s = s + vecs[4].d[i];
    end
    vecs[4].csum = s;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], (i == 0) ? 0 : 2, 1'b0);

    // Reset lands one cycle after the first payload byte: that write finishes, nothing follows.
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    exp_q.push_back({12'h010, 8'hA9});
    send_byte(8'hA9, 0);
    ifc.inData = 8'h05;
    reset = 1'b0;
    tick();
    check_reset_vals("midload_reset");
    chk("midload_writes_drained", exp_q.size(), 32'h0);
    ifc.inValid = 1'b0;
    reset = 1'b1;
    tick();
    run_vec(vecs[0], 0, 1'b0);

    run_vec(vecs[2], 1, 1'b1);

    repeat (3) tick();
    chk("final_no_stray_writes", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/chipmunk_loader.md
CHIPMUNK_LOADER -- requirements
Module: chipmunk_loader

Interface
REQ-001 Parameter addrSize, default 12: CPU/memory address width in bits.
REQ-002 Parameter WDOG_CYCLES, default 65535: run-phase watchdog limit in clock cycles.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-low.
REQ-005 start  input  1  one-cycle request to begin a load/run sequence.
REQ-006 inData  input  8  serial image byte.
REQ-007 inValid  input  1  inData holds a byte.
REQ-008 inReady  output  1  loader accepts a byte this cycle; transfer = inValid && inReady.
REQ-009 memAddr  output  addrSize  memory write address.
REQ-010 memData  output  8  memory write data.
REQ-011 weMem  output  1  active-low memory write enable, one full cycle per byte.
REQ-012 memSel  output  1  high = loader owns memory bus, low = CPU owns it.
REQ-013 cpuReset  output  1  active-low reset to the CPU core.
REQ-014 cpuStartPC  output  addrSize  start address presented to the CPU.
REQ-015 cpuDone  input  1  CPU halt indication.
REQ-016 busy  output  1  sequence in progress (any state except IDLE, DONE, ERR).
REQ-017 runDone  output  1  CPU halted normally.
REQ-018 loadError  output  1  sequence aborted; errCode valid.
REQ-019 errCode  output  2  01 checksum mismatch, 10 watchdog expiry, 00 none.

Function
REQ-020 States: IDLE, LEN_LO, LEN_HI, ADR_LO, ADR_HI, DATA, CSUM, RUN, DONE, ERR.
REQ-021 IDLE, DONE or ERR + start -> LEN_LO; clear runDone, loadError, errCode and the checksum accumulator; start is ignored in all other states.
REQ-022 inReady = 1 exactly in LEN_LO, LEN_HI, ADR_LO, ADR_HI, DATA, CSUM; each accepted byte advances the state by one header field.
REQ-023 Header is little-endian: 16-bit byte length, then 16-bit load address; only bits [addrSize-1:0] are kept from each.
REQ-024 After ADR_HI: length 0 -> CSUM; otherwise -> DATA; cpuStartPC = load address from this cycle on.
REQ-025 DATA: each accepted byte is written at the current address; memAddr/memData registered, weMem low for exactly the cycle after acceptance; address increments modulo 2^addrSize; remaining count decrements.
REQ-026 DATA -> CSUM on acceptance of the last payload byte; back-to-back bytes (inValid held high) are accepted every cycle.
REQ-027 Checksum = 8-bit modular sum of payload bytes; CSUM byte equal -> RUN; unequal -> ERR with errCode 01.
REQ-028 memSel = 1 from LEN_LO through CSUM, and in the cycle of the final write; 0 otherwise.
REQ-029 RUN: cpuReset = 1 starting the cycle after entering RUN; cpuReset = 0 in every other state.
REQ-030 RUN + cpuDone = 1 -> DONE, runDone = 1; cpuDone is ignored outside RUN.
REQ-031 Header or payload stall (inValid low) holds state indefinitely; no timeout applies during load.

Reset
REQ-032 reset low at a clock edge -> state IDLE, inReady 0, weMem 1, memSel 0, cpuReset 0, cpuStartPC 0, busy 0, runDone 0, loadError 0, errCode 00, counters 0.
REQ-033 Reset mid-load aborts without a further write; any write already issued completes its cycle only if reset was high at that edge.

Configuration
REQ-034 Macro LOADER_WATCHDOG_EN defined: a counter clears on RUN entry, increments each RUN cycle; reaching WDOG_CYCLES without cpuDone -> ERR, errCode 10, cpuReset 0; cpuDone in the same cycle as expiry wins (DONE).
REQ-035 LOADER_WATCHDOG_EN undefined: no counter exists; RUN waits for cpuDone indefinitely; errCode 10 never produced.

Verification
REQ-036 start; stream 03 00 10 00 A9 05 83 31 -> writes 0x010=A9, 0x011=05, 0x012=83; RUN; cpuStartPC=0x010; cpuDone -> runDone=1.
REQ-037 Same image with checksum 30 -> ERR, errCode 01, cpuReset stays 0, no write after the third byte.
REQ-038 Length 0000, address 0x200, checksum 00 -> no weMem pulse; RUN with cpuStartPC=0x200.
REQ-039 Length 0002, address 0xFFF, bytes 11 22 -> writes 0xFFF=11, 0x000=22 (wrap).
REQ-040 Reset low during DATA after 1 of 3 bytes -> all outputs at reset values next cycle; start replays cleanly.
REQ-041 With LOADER_WATCHDOG_EN, WDOG_CYCLES=16, cpuDone held 0 -> ERR, errCode 10 after 16 RUN cycles.
